clkout_gen_tech: RTL and testbench

Programmable, glitch-free clock-output generator for the techmap layer. It produces a divided, registered clock, `o_clk`, from the buffered system clock and drives it toward a pad or output buffer, for example as an external device clock or SPI SCLK. Start and stop are requested with a level enable. The output always completes its current period, stops only at its idle level, and never emits a runt pulse. Edge strobes are provided for logic that samples or launches data relative to the forwarded clock.

---
 rtl/clkgen_pkg.sv | 10 +
 rtl/clkout_gen_tech.sv | 105 ++++++++++
 tb/tb_clkout_gen_tech.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/clkgen_pkg.sv
// Shared types for the clock-output generator.
package clkgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } clkgen_state_t;

endpackage

// File: rtl/clkout_gen_tech.sv
// Glitch-free programmable clock-output generator: registered divided clock,
// graceful whole-period stop at the idle level, and edge strobes.
module clkout_gen_tech
  import clkgen_pkg::*;
#(
  parameter int unsigned SCALER_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ena,
  input  logic [SCALER_WIDTH-1:0] i_scaler,
  input  logic                    i_idle_level,
  output logic                    o_clk,
  output logic                    o_posedge,
  output logic                    o_negedge,
  output logic                    o_busy
);

  clkgen_state_t           state_q, state_d;
  logic [SCALER_WIDTH-1:0] cnt_q, cnt_d;
  logic [SCALER_WIDTH-1:0] scaler_q, scaler_d;
  logic                    idle_q, idle_d;
  logic                    clk_q, clk_d;
  logic                    pos_q, pos_d;
  logic                    neg_q, neg_d;
  logic                    busy_q, busy_d;
  logic                    toggle;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scaler_d = scaler_q;
    idle_d   = idle_q;
    clk_d    = clk_q;
    pos_d    = 1'b0;
    neg_d    = 1'b0;
    toggle   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_ena) begin
          state_d  = RUN;
          scaler_d = i_scaler;
          idle_d   = i_idle_level;
        end else begin
          clk_d = i_idle_level;
        end
      end

      RUN, STOP: begin
        if (cnt_q == scaler_q) begin
          toggle = 1'b1;
          clk_d  = ~clk_q;
          cnt_d  = '0;
          pos_d  = ~clk_q;
          neg_d  = clk_q;
        end else begin
          cnt_d = cnt_q + SCALER_WIDTH'(1);
        end

        // A re-request in STOP wins over the final toggle; the toggle still happens.
        if (state_q == RUN) begin
          if (!i_ena) state_d = STOP;
        end else if (i_ena) begin
          state_d = RUN;
        end else if (toggle && (clk_d == idle_q)) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      scaler_q <= '0;
      idle_q   <= 1'b0;
      clk_q    <= 1'b0;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scaler_q <= scaler_d;
      idle_q   <= idle_d;
      clk_q    <= clk_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
    end
  end

  assign o_clk     = clk_q;
  assign o_posedge = pos_q;
  assign o_negedge = neg_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_clkout_gen_tech.sv
// Scoreboard bench for clkout_gen_tech: a behavioural model predicts each
// cycle's outputs into a queue; a monitor pops and compares after every edge.
module tb_clkout_gen_tech;

  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [SW-1:0] scaler = '0;
  logic          idle_lvl = 1'b0;
  logic          o_clk, o_pos, o_neg, o_busy;

  clkout_gen_tech #(.SCALER_WIDTH(SW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ena       (ena),
    .i_scaler    (scaler),
    .i_idle_level(idle_lvl),
    .o_clk       (o_clk),
    .o_posedge   (o_pos),
    .o_negedge   (o_neg),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // Expected {o_clk, o_posedge, o_negedge, o_busy} per clock edge.
  logic [3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0=stopped, 1=running, 2=draining.
  int   m_mode    = 0;
  int   m_half    = 1;
  int   m_elapsed = 0;
  bit   m_clk     = 0;
  bit   m_idle    = 0;

  task automatic model_step(input bit r, input bit e, input int sc, input bit il);
    bit p, n, t;
    p = 0; n = 0; t = 0;
    if (r) begin
      m_mode = 0; m_half = 1; m_elapsed = 0; m_clk = 0; m_idle = 0;
    end else if (m_mode == 0) begin
      if (e) begin
        m_mode = 1; m_half = sc + 1; m_elapsed = 0; m_idle = il;
      end else begin
        m_clk = il;
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == m_half) begin
        t = 1; m_clk = !m_clk; m_elapsed = 0;
        p = m_clk; n = !m_clk;
      end
      if (m_mode == 1) begin
        if (!e) m_mode = 2;
      end else if (e) begin
        m_mode = 1;
      end else if (t && m_clk == m_idle) begin
        m_mode = 0;
      end
    end
    exp_q.push_back({m_clk, p, n, (m_mode != 0)});
  endtask

  task automatic cyc(input bit r, input bit e, input int sc, input bit il);
    @(negedge clk);
    rst = r; ena = e; scaler = SW'(sc); idle_lvl = il;
    model_step(r, e, sc, il);
  endtask

  task automatic cycn(input int n, input bit r, input bit e, input int sc, input bit il);
    for (int i = 0; i < n; i++) cyc(r, e, sc, il);
  endtask

  // Monitor
  initial begin
    logic [3:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {o_clk, o_pos, o_neg, o_busy};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL outputs t=%0t {clk,pos,neg,busy} actual=%b required=%b",
                   $time, act_v, exp_v);
        end
        if (o_pos === 1'b1 && o_neg === 1'b1) begin
          failures++;
          $display("FAIL strobes_exclusive t=%0t actual pos=1 neg=1 required not both", $time);
        end
      end
    end
  end

  initial begin
    int sc_r;
    bit e_r, il_r;
    // Reset with idle level 1, then idle tracking.
    cycn(3, 1, 0, 0, 1);
    cycn(4, 0, 0, 0, 1);
    cycn(3, 0, 0, 0, 0);
    // Basic run, scaler 3, then drain.
    cycn(40, 0, 1, 3, 0);
    cycn(20, 0, 0, 3, 0);
    // Scaler 2: run, stop when high with cnt 0.
    cycn(4, 0, 1, 2, 0);
    cycn(15, 0, 0, 2, 0);
    // Stop for 2 cycles while low, then re-enable.
    cycn(20, 0, 1, 3, 0);
    cycn(2, 0, 0, 3, 0);
    cycn(20, 0, 1, 3, 0);
    cycn(20, 0, 0, 3, 0);
    // Divide-by-2, scaler change while busy ignored, idle level 1.
    cycn(8, 0, 1, 0, 1);
    cycn(8, 0, 1, 5, 0);
    cycn(10, 0, 0, 5, 0);
    cycn(30, 0, 1, 5, 0);
    // Reset mid-run.
    cycn(7, 0, 1, 2, 0);
    cyc(1, 1, 2, 0);
    cycn(5, 0, 0, 2, 0);
    // Random stimulus.
    e_r = 0; sc_r = 0; il_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) e_r = !e_r;
      if ($urandom_range(0, 4) == 0) sc_r = $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) il_r = !il_r;
      cyc(($urandom_range(0, 299) == 0), e_r, sc_r, il_r);
    end
    cycn(30, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
